// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and frame builder for the PS/2 device-side transmitter.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        KB_IDLE,
        KB_SEND,
        KB_GAP
    } kb_state_t;

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_HIGH,
        BIT_LOW
    } bit_state_t;

    // Bit 0 goes on the wire first: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Sends one 11-bit PS/2 frame: half-period divider plus HIGH/LOW bit FSM.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       frame_done
);

    localparam int              CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   DIV_LOAD = CW'(CLK_DIV - 1);
    localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    bit_state_t                  state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [3:0]                  idx_q, idx_d;
    logic [PS2_FRAME_BITS-1:0]   shift_q, shift_d;
    logic                        clk_d, data_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        clk_d      = ps2_clk;
        data_d     = ps2_data;
        frame_done = 1'b0;
        unique case (state_q)
            BIT_IDLE: begin
                if (start) begin
                    shift_d = ps2_frame(tx_byte);
                    state_d = BIT_HIGH;
                    cnt_d   = DIV_LOAD;
                    idx_d   = '0;
                    clk_d   = 1'b1;
                    data_d  = shift_d[0];
                end
            end
            BIT_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = BIT_LOW;
                    cnt_d   = DIV_LOAD;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            BIT_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (idx_q == LAST_BIT) begin
                    state_d    = BIT_IDLE;
                    clk_d      = 1'b1;
                    data_d     = 1'b1;
                    frame_done = 1'b1;
                end else begin
                    // Data only moves here, on entry to HIGH, so it is stable across every falling edge.
                    state_d = BIT_HIGH;
                    cnt_d   = DIV_LOAD;
                    idx_d   = idx_q + 4'd1;
                    shift_d = shift_q >> 1;
                    clk_d   = 1'b1;
                    data_d  = shift_q[1];
                end
            end
            default: state_d = BIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= BIT_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ps2_clk  <= clk_d;
            ps2_data <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Keyboard-side PS/2 transmitter: key-event handshake, prefix byte sequencer and inter-frame gap.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [7:0] key_code,
    input  logic       key_release,
    input  logic       key_ext,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       done
);

    localparam int            GW       = $clog2(GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    kb_state_t      state_q, state_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [15:0]    rem_q, rem_d;
    logic [1:0]     rem_cnt_q, rem_cnt_d;
    logic           start, frame_done;
    logic [7:0]     tx_byte;
    logic [7:0]     first_byte;
    logic [15:0]    rest_bytes;
    logic [1:0]     rest_cnt;

    // First byte goes straight to the framer; the rest queue low byte first.
    always_comb begin
        first_byte = key_code;
        rest_bytes = '0;
        rest_cnt   = 2'd0;
        if (key_ext) begin
            first_byte = PS2_EXT;
            if (key_release) begin
                rest_bytes = {key_code, PS2_BREAK};
                rest_cnt   = 2'd2;
            end else begin
                rest_bytes = {8'h00, key_code};
                rest_cnt   = 2'd1;
            end
        end else if (key_release) begin
            first_byte = PS2_BREAK;
            rest_bytes = {8'h00, key_code};
            rest_cnt   = 2'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        rem_d     = rem_q;
        rem_cnt_d = rem_cnt_q;
        start     = 1'b0;
        tx_byte   = rem_q[7:0];
        done      = 1'b0;
        key_ready = (state_q == KB_IDLE);
        busy      = (state_q != KB_IDLE);
        unique case (state_q)
            KB_IDLE: begin
                tx_byte = first_byte;
                if (key_valid) begin
                    start     = 1'b1;
                    state_d   = KB_SEND;
                    rem_d     = rest_bytes;
                    rem_cnt_d = rest_cnt;
                end
            end
            KB_SEND: begin
                if (frame_done) begin
                    state_d = KB_GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            KB_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (rem_cnt_q != 2'd0) begin
                    start     = 1'b1;
                    state_d   = KB_SEND;
                    rem_d     = {8'h00, rem_q[15:8]};
                    rem_cnt_d = rem_cnt_q - 2'd1;
                end else begin
                    state_d = KB_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = KB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= KB_IDLE;
            gap_q     <= '0;
            rem_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            rem_cnt_q <= rem_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
    end

    ps2_frame_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_frame (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tx_byte   (tx_byte),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .frame_done(frame_done)
    );

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: vector table, random key events against a byte-level model, and a wire monitor.
module tb_ps2_kbd_tx;

    localparam int CLK_DIV   = 4;
    localparam int GAP       = 8;
    localparam int FRAME_CYC = 22 * CLK_DIV + GAP;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_release = 1'b0;
    logic       key_ext = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_ready, ps2_clk, ps2_data, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] code;
        logic       rel;
        logic       ext;
        int         exp_done;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_kbd_tx #(
        .CLK_DIV(CLK_DIV),
        .GAP    (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_code   (key_code),
        .key_release(key_release),
        .key_ext    (key_ext),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .done       (done)
    );

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Reference model: the byte list a key event must put on the wire.
    function automatic int model_push(input logic [7:0] code, input logic rel, input logic ext);
        int n = 0;
        if (ext) begin exp_q.push_back(8'hE0); n++; end
        if (rel) begin exp_q.push_back(8'hF0); n++; end
        exp_q.push_back(code);
        return n + 1;
    endfunction

    // Wire monitor, sampled mid-cycle.
    logic        prev_clk = 1'b1;
    logic        prev_data = 1'b1;
    int          nbits = 0;
    int          fall_cnt = 0;
    int          last_fall = -1;
    logic [10:0] fbits = '0;

    always @(negedge clk) begin
        if (!reset) begin
            nbits     = 0;
            last_fall = -1;
        end else begin
            if (prev_clk == 1'b0 && ps2_clk == 1'b0)
                chk("data_stable_while_low", ps2_data, prev_data);
            if (prev_clk == 1'b1 && ps2_clk == 1'b0) begin
                fall_cnt++;
                if (last_fall >= 0) begin
                    if (nbits == 0) begin
                        checks++;
                        if (cyc - last_fall < 2 * CLK_DIV + GAP) begin
                            errors++;
                            $display("FAIL inter_frame_gap: got %0d cycles required >= %0d",
                                     cyc - last_fall, 2 * CLK_DIV + GAP);
                        end
                    end else begin
                        chk("bit_period", cyc - last_fall, 2 * CLK_DIV);
                    end
                end
                last_fall = cyc;
                fbits[4'(nbits)] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    nbits = 0;
                    chk("start_bit", fbits[0], 0);
                    chk("stop_bit", fbits[10], 1);
                    chk("odd_parity", ^fbits[9:1], 1);
                    if (exp_q.size() == 0) fail_now("unexpected_frame");
                    else chk("frame_byte", fbits[8:1], exp_q.pop_front());
                end
            end
        end
        prev_clk  = ps2_clk;
        prev_data = ps2_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 2000; i++) begin
            if (key_ready) return;
            tick();
        end
        fail_now("wait_ready_timeout");
    endtask

    task automatic wait_done(input int ta, input string name, input int exp_done);
        bit got = 0;
        for (int i = 1; i <= 2000; i++) begin
            tick();
            if (cyc - ta == CLK_DIV - 1) chk({name, "_clk_high_before_fall"}, ps2_clk, 1);
            if (cyc - ta == CLK_DIV)     chk({name, "_first_fall"}, ps2_clk, 0);
            if (done) begin got = 1; break; end
        end
        if (!got) fail_now({name, "_done_timeout"});
        else chk({name, "_done_time"}, cyc - ta + 1, exp_done);
    endtask

    task automatic run_event(input logic [7:0] code, input logic rel, input logic ext, input int exp_done);
        int ta, f0, n;
        wait_ready();
        n = model_push(code, rel, ext);
        f0 = fall_cnt;
        key_code = code; key_release = rel; key_ext = ext; key_valid = 1'b1;
        tick();
        ta = cyc;
        key_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", key_ready, 0);
        chk("start_bit_level", ps2_data, 0);
        chk("clk_high_at_start", ps2_clk, 1);
        wait_done(ta, "event", exp_done);
        chk("falls_per_event", fall_cnt - f0, 11 * n);
        tick();
        chk("done_one_cycle", done, 0);
        chk("ready_after_done", key_ready, 1);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        int ta, tb2, f0, f1, n;
        bit got;
        logic [7:0] rc;
        logic rr, re;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 96};
        vecs[1] = '{8'h1C, 1'b1, 1'b0, 192};
        vecs[2] = '{8'h75, 1'b1, 1'b1, 288};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 96};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 96};
        vecs[5] = '{8'h5A, 1'b0, 1'b1, 192};

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        chk("reset_ps2_clk", ps2_clk, 1);
        chk("reset_ps2_data", ps2_data, 1);
        chk("reset_key_ready", key_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b1;
        repeat (2) tick();

        foreach (vecs[i]) run_event(vecs[i].code, vecs[i].rel, vecs[i].ext, vecs[i].exp_done);

        // key_valid held through a busy event: second accepted right after done
        wait_ready();
        void'(model_push(8'h1C, 1'b0, 1'b0));
        key_code = 8'h1C; key_release = 1'b0; key_ext = 1'b0; key_valid = 1'b1;
        tick();
        ta = cyc;
        key_code = 8'h2A;
        void'(model_push(8'h2A, 1'b0, 1'b0));
        got = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (key_ready) begin got = 1; break; end
        end
        if (!got) fail_now("held_ready_timeout");
        else chk("held_ready_time", cyc - ta + 1, 97);
        tick();
        tb2 = cyc;
        key_valid = 1'b0;
        chk("held_second_accepted", busy, 1);
        chk("held_second_ready_low", key_ready, 0);
        chk("held_second_start_bit", ps2_data, 0);
        wait_done(tb2, "held", 96);
        tick();
        chk("held_ready_after_done", key_ready, 1);

        // Reset during the LOW phase of data bit 4
        wait_ready();
        f0 = fall_cnt;
        key_code = 8'h1C; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (fall_cnt - f0 >= 6) begin got = 1; break; end
        end
        if (!got) fail_now("reset_seq_fall_timeout");
        chk("reset_seq_in_low", ps2_clk, 0);
        reset = 1'b0;
        tick();
        chk("midreset_ps2_clk", ps2_clk, 1);
        chk("midreset_ps2_data", ps2_data, 1);
        chk("midreset_key_ready", key_ready, 1);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        reset = 1'b1;
        f1 = fall_cnt;
        repeat (40) tick();
        chk("no_falls_after_reset", fall_cnt - f1, 0);
        run_event(8'h1C, 1'b0, 1'b0, 96);

        // Random key events
        for (int k = 0; k < 16; k++) begin
            rc = 8'($urandom_range(0, 255));
            rr = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            n = 1 + int'(rr) + int'(re);
            run_event(rc, rr, re, n * FRAME_CYC);
        end

        repeat (5) tick();
        chk("expected_frames_all_seen", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
